expr_tx: RTL and testbench

EXPR_TX -- requirements
Module: expr_tx

---
 rtl/expr_tx.sv | 158 +++++++++++++++
 tb/tb_expr_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_tx.sv
// expr_tx: serialises a short arithmetic expression of BCD operands as ASCII.
// A request carries 1..4 operand nibbles and one "+"/"*" operator per gap;
// characters leave on a valid/ready port, digits and operators alternating.
//
// Optional build macro EXPR_TX_CHECK_EN: when defined, malformed requests
// (cnt outside 1..4, or a used nibble above 9) are rejected with an err
// pulse. When undefined, cnt is clamped into 1..4, nibbles are sent raw and
// err stays low.
//
// Handshake: a character transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out and out_valid hold
// steady. out reads 8'h00 whenever out_valid=0.
module expr_tx (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [2:0]  cnt,
    input  logic [15:0] digits,
    input  logic [2:0]  ops,
    output logic [7:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  cnt_r;
    logic [15:0] digits_r;
    logic [2:0]  ops_r;
    logic [1:0]  idx;
    logic [2:0]  eff_cnt;

    // ASCII for operand i of a packed nibble word
    function automatic logic [7:0] digit_char(input logic [15:0] d, input logic [1:0] i);
        return 8'h30 + {4'h0, d[{i, 2'b00} +: 4]};
    endfunction

    // ASCII for the operator sitting after operand i
    function automatic logic [7:0] op_char(input logic [2:0] o, input logic [1:0] i);
        return o[i] ? 8'h2A : 8'h2B;
    endfunction

    // Operand count folded into the legal 1..4 range
    always_comb begin
        eff_cnt = cnt;
        if (cnt == 3'd0)
            eff_cnt = 3'd1;
        else if (cnt > 3'd4)
            eff_cnt = 3'd4;
    end

`ifdef EXPR_TX_CHECK_EN
    logic req_bad;
    logic err_r;

    // Flag an incoming request whose count or used nibbles are out of range
    always_comb begin
        req_bad = (cnt == 3'd0) || (cnt > 3'd4);
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) < cnt) && (digits[4*k +: 4] > 4'd9))
                req_bad = 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Sequencer: state, captured request and registered outputs move together
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            cnt_r     <= 3'd0;
            digits_r  <= 16'h0000;
            ops_r     <= 3'd0;
            idx       <= 2'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef EXPR_TX_CHECK_EN
            err_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef EXPR_TX_CHECK_EN
            err_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef EXPR_TX_CHECK_EN
                        if (req_bad) begin
                            err_r <= 1'b1;
                        end else
`endif
                        begin
                            cnt_r     <= eff_cnt;
                            digits_r  <= digits;
                            ops_r     <= ops;
                            idx       <= 2'd0;
                            state     <= DIGIT;
                            out       <= digit_char(digits, 2'd0);
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                DIGIT: begin
                    if (out_ready) begin
                        if (({1'b0, idx} + 3'd1) < cnt_r) begin
                            state <= OP;
                            out   <= op_char(ops_r, idx);
                        end else begin
                            // last operand sent: one quiet cycle announcing done
                            state     <= FIN;
                            out       <= 8'h00;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                OP: begin
                    if (out_ready) begin
                        idx   <= idx + 2'd1;
                        state <= DIGIT;
                        out   <= digit_char(digits_r, idx + 2'd1);
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    out       <= 8'h00;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: hand-computed character sequences are queued
// per request and compared against every transfer seen on the output port.
module tb_expr_tx;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [2:0]  cnt;
    logic [15:0] digits;
    logic [2:0]  ops;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    expr_tx dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .cnt       (cnt),
        .digits    (digits),
        .ops       (ops),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raise start with the given request, step to the first offered character.
    task automatic launch(input logic [2:0] c, input logic [15:0] d, input logic [2:0] o,
                          input bit keep_start);
        cnt       = c;
        digits    = d;
        ops       = o;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep_start) begin
            start = 1'b0;
            // request inputs are ignored once busy; scramble them
            cnt    = 3'($urandom_range(0, 7));
            digits = 16'($urandom);
            ops    = 3'($urandom_range(0, 7));
        end
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
    endtask

    // Drain one transmission against exp_q, optionally stalling one character.
    task automatic collect(input int stall_at, input int stall_len);
        int  n_exp;
        int  nsent;
        int  stalled;
        int  cyc;
        bit  seen_done;
        n_exp     = exp_q.size();
        nsent     = 0;
        stalled   = 0;
        cyc       = 0;
        seen_done = 0;
        for (int i = 0; i < 64; i++) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (!out_valid) begin
                check("valid_gap", 32'(out_valid), 32'd1);
            end else if (exp_q.size() == 0) begin
                check("extra_char", 32'(out), 32'd0);
                break;
            end else if (nsent == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                check("held_char", 32'(out), 32'(exp_q[0]));
            end else begin
                out_ready = 1'b1;
                check("char", 32'(out), 32'(exp_q.pop_front()));
                nsent++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("done_seen", 32'(seen_done), 32'd1);
        check("char_count", 32'(nsent), 32'(n_exp));
        check("cycle_count", 32'(cyc), 32'(n_exp + stall_len));
        check("fin_out", {23'd0, out_valid, out}, 32'd0);
        check("fin_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int  quiet_valid;
        int  quiet_done;
        clr_n     = 1'b0;
        start     = 1'b0;
        cnt       = 3'd0;
        digits    = 16'h0000;
        ops       = 3'd0;
        out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        // 7+2*5
        exp_q = '{8'h37, 8'h2B, 8'h32, 8'h2A, 8'h35};
        launch(3'd3, 16'h0527, 3'b010, 1'b0);
        collect(-1, 0);

        // single operand
        exp_q = '{8'h39};
        launch(3'd1, 16'h0009, 3'b000, 1'b0);
        collect(-1, 0);

        // 7+2*5 with a 3-cycle stall on "+"
        exp_q = '{8'h37, 8'h2B, 8'h32, 8'h2A, 8'h35};
        launch(3'd3, 16'h0527, 3'b010, 1'b0);
        collect(1, 3);

        // all four operands, mixed operators
        exp_q = '{8'h31, 8'h2A, 8'h32, 8'h2B, 8'h33, 8'h2A, 8'h34};
        launch(3'd4, 16'h4321, 3'b101, 1'b0);
        collect(-1, 0);

        // reset while the second digit is offered
        launch(3'd3, 16'h0527, 3'b010, 1'b0);
        check("abort_c0", 32'(out), 32'h37);
        @(negedge clk);
        check("abort_c1", 32'(out), 32'h2B);
        @(negedge clk);
        check("abort_c2", 32'(out), 32'h32);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        quiet_valid = 0;
        quiet_done  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) quiet_valid++;
            if (done) quiet_done++;
        end
        check("abort_quiet_valid", 32'(quiet_valid), 32'd0);
        check("abort_quiet_done", 32'(quiet_done), 32'd0);

`ifdef EXPR_TX_CHECK_EN
        // nibble above 9 in a used position is rejected
        cnt    = 3'd2;
        digits = 16'h00A0;
        ops    = 3'd0;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rej_err", 32'(err), 32'd1);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rej_err_pulse", 32'(err), 32'd0);
        check("rej_busy2", 32'(busy), 32'd0);

        // cnt out of range is rejected
        cnt    = 3'd0;
        digits = 16'h0004;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rej0_err", 32'(err), 32'd1);
        check("rej0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        cnt   = 3'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rej7_err", 32'(err), 32'd1);
        check("rej7_busy", 32'(busy), 32'd0);
        @(negedge clk);
`else
        // raw nibble 0xA goes out as ':'
        exp_q = '{8'h30, 8'h2B, 8'h3A};
        launch(3'd2, 16'h00A0, 3'b000, 1'b0);
        collect(-1, 0);

        // cnt=0 behaves as one operand
        exp_q = '{8'h34};
        launch(3'd0, 16'h0004, 3'b000, 1'b0);
        collect(-1, 0);

        // cnt=7 behaves as four operands
        exp_q = '{8'h31, 8'h2A, 8'h32, 8'h2B, 8'h33, 8'h2A, 8'h34};
        launch(3'd7, 16'h4321, 3'b101, 1'b0);
        collect(-1, 0);
        check("err_low", 32'(err), 32'd0);
`endif

        // start held high: next request only after the IDLE cycle
        exp_q = '{8'h31, 8'h2A, 8'h33};
        launch(3'd2, 16'h0031, 3'b001, 1'b1);
        collect(-1, 0);
        @(negedge clk);
        start = 1'b0;
        exp_q = '{8'h31, 8'h2A, 8'h33};
        check("rearm_busy", 32'(busy), 32'd1);
        check("rearm_valid", 32'(out_valid), 32'd1);
        collect(-1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
